modulo_job_sequencer: RTL and testbench
=======================================

# modulo_job_sequencer

Host-side initiator for the repeated-subtraction modulo unit. It accepts operand pairs over a valid/ready request port and drives the unit's operands plus a one-cycle start pulse. It waits for the unit's completion flag, then returns the remainder over a valid/ready response port. It also short-circuits a zero divisor, and optionally aborts hung jobs with a watchdog.

## Interface
- `WIDTH`, 32: operand and remainder width.
- `TIMEOUT_CYCLES`, 1024: WAIT-state cycle limit. Used only with `MOD_SEQ_TIMEOUT_EN`; legal range 2..2^16.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  host offers an operand pair.
- `req_ready_o`  out  1  sequencer can accept a pair.
- `zahl1_i`  in  WIDTH  dividend.
- `zahl2_i`  in  WIDTH  divisor.
- `resp_valid_o`  out  1  response available.
- `resp_ready_i`  in  1  host consumes the response.
- `resp_rest_o`  out  WIDTH  remainder.
- `resp_err_o`  out  1  zero divisor, or watchdog abort.
- `mod_start_o`  out  1  start pulse to the modulo unit.
- `mod_zahl1_o`  out  WIDTH  dividend to the unit.
- `mod_zahl2_o`  out  WIDTH  divisor to the unit.
- `mod_valid_i`  in  1  unit finished; remainder valid.
- `mod_erg_i`  in  WIDTH  unit result.
- `mod_rst_o`  out  1  abort reset to the unit; OR'd with `rst` at the unit.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, LAUNCH, WAIT, ABORT (only with the macro), RESP.
- **IDLE**
  - `req_ready_o` = 1 (forced 0 while `rst` is high).
  - On handshake (`req_valid_i & req_ready_o`), capture `zahl1_i`/`zahl2_i` into the registers driving `mod_zahl1_o`/`mod_zahl2_o`.
  - If `zahl2_i` == 0: load `resp_rest_o` = `zahl1_i`, `resp_err_o` = 1, go to RESP.
  - Otherwise go to LAUNCH.
- **LAUNCH:** `mod_start_o` = 1 for exactly this one cycle, then WAIT.
- **Operand hold:** `mod_zahl1_o`/`mod_zahl2_o` stay stable from the capture until the next handshake; the unit latches them late.
- **WAIT**
  - When `mod_valid_i` is sampled high: capture `mod_erg_i` into `resp_rest_o`, set `resp_err_o` = 0, go to RESP.
  - `mod_valid_i` is ignored in every other state.
- **RESP**
  - `resp_valid_o` = 1; `resp_rest_o`/`resp_err_o` held stable.
  - On `resp_ready_i` sampled high, go to IDLE.
- **Outstanding jobs:** at most one; no request is accepted before the response is consumed.
- **Arithmetic:** unsigned; no width conversion. `resp_rest_o` is exactly `mod_erg_i`.

## Timing
- **Reset values:** `req_ready_o`, `resp_valid_o`, `resp_err_o`, `mod_start_o`, `mod_rst_o`, `busy_o` = 0; `resp_rest_o`, `mod_zahl1_o`, `mod_zahl2_o` = 0; state = IDLE.
  - `req_ready_o` = 1 in the first cycle after `rst` falls.
- **Normal job (handshake at edge k):**
  - `mod_start_o` high during cycle k+1 only.
  - WAIT from k+2.
  - `mod_valid_i` sampled at edge m gives `resp_valid_o` = 1 from m+1.
- **Zero divisor (handshake at edge k):** `resp_valid_o` = 1 from k+1; `mod_start_o` never asserted.
- **Response handshake at edge r:** `req_ready_o` = 1 from r+1. Back-to-back throughput is limited by this single IDLE cycle.
- **Reset mid-operation:** the job is abandoned and no response is produced. A response pending in RESP is discarded.
- **Stray valid:** `mod_valid_i` high in IDLE, LAUNCH, ABORT or RESP has no effect.

## Configuration
- **`MOD_SEQ_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If the count reaches `TIMEOUT_CYCLES`-1 with `mod_valid_i` low, go to ABORT.
  - ABORT: `mod_rst_o` = 1 for exactly 2 cycles, then RESP with `resp_rest_o` = 0, `resp_err_o` = 1.
  - If `mod_valid_i` and expiry occur in the same cycle, `mod_valid_i` wins.
- **Not defined:**
  - No counter and no ABORT state; WAIT is unbounded.
  - `mod_rst_o` is tied to 0.
  - `resp_err_o` is set only for a zero divisor.

## Test plan
- Request 17 mod 5, with the unit modelled at 12-cycle latency:
  - `mod_start_o` pulses exactly one cycle, at k+1.
  - Response `resp_rest_o` = 2, `resp_err_o` = 0.
- Request 4 mod 9 → `resp_rest_o` = 4, `resp_err_o` = 0; `mod_zahl1_o`/`mod_zahl2_o` stay 4/9 throughout WAIT.
- Request 123 mod 0:
  - `resp_valid_o` high at k+1, `resp_rest_o` = 123, `resp_err_o` = 1.
  - `mod_start_o` stays 0.
- Backpressure on 100 mod 7:
  - Hold `resp_ready_i` low 10 cycles: `resp_rest_o` = 2 stays stable and `req_ready_o` = 0.
  - Raise `resp_ready_i`: `req_ready_o` = 1 the next cycle.
- With `MOD_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16, and a unit that never asserts valid:
  - `mod_rst_o` goes high for 2 cycles, then the response has `resp_err_o` = 1, `resp_rest_o` = 0.
  - A stray `mod_valid_i` pulse in IDLE afterwards has no effect.
- Assert `rst` during WAIT of 50 mod 3:
  - All outputs go to 0 and no response appears.
  - A following request of 100 mod 7 returns 2.

Source files
------------

// File: rtl/modulo_job_sequencer.sv
// Host-side initiator for the repeated-subtraction modulo unit: request/response
// valid/ready ports, zero-divisor bypass, optional WAIT watchdog (MOD_SEQ_TIMEOUT_EN).
module modulo_job_sequencer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] zahl1_i,
  input  logic [WIDTH-1:0] zahl2_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_rest_o,
  output logic             resp_err_o,
  output logic             mod_start_o,
  output logic [WIDTH-1:0] mod_zahl1_o,
  output logic [WIDTH-1:0] mod_zahl2_o,
  input  logic             mod_valid_i,
  input  logic [WIDTH-1:0] mod_erg_i,
  output logic             mod_rst_o,
  output logic             busy_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..65536");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
`ifdef MOD_SEQ_TIMEOUT_EN
    S_ABORT,
`endif
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic   req_hs;
  logic   zero_div;

`ifdef MOD_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt_q;
  logic        abort_cnt_q;
`endif

  assign zero_div = (zahl2_i == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_hs  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !rst) begin
          req_hs  = 1'b1;
          state_d = zero_div ? S_RESP : S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (mod_valid_i) state_d = S_RESP;
`ifdef MOD_SEQ_TIMEOUT_EN
        else if (wd_cnt_q == WD_LAST) state_d = S_ABORT;
`endif
      end
`ifdef MOD_SEQ_TIMEOUT_EN
      S_ABORT: if (abort_cnt_q) state_d = S_RESP;
`endif
      S_RESP: if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o  = (state_q == S_IDLE) && !rst;
  assign resp_valid_o = (state_q == S_RESP);
  assign mod_start_o  = (state_q == S_LAUNCH);
  assign busy_o       = (state_q != S_IDLE);

  // Operand registers change only on a request handshake, so the unit may latch late.
  always_ff @(posedge clk) begin
    if (rst) begin
      mod_zahl1_o <= '0;
      mod_zahl2_o <= '0;
      resp_rest_o <= '0;
      resp_err_o  <= 1'b0;
    end else begin
      if (req_hs) begin
        mod_zahl1_o <= zahl1_i;
        mod_zahl2_o <= zahl2_i;
        if (zero_div) begin
          resp_rest_o <= zahl1_i;
          resp_err_o  <= 1'b1;
        end
      end
      if (state_q == S_WAIT && mod_valid_i) begin
        resp_rest_o <= mod_erg_i;
        resp_err_o  <= 1'b0;
      end
`ifdef MOD_SEQ_TIMEOUT_EN
      if (state_q == S_ABORT && abort_cnt_q) begin
        resp_rest_o <= '0;
        resp_err_o  <= 1'b1;
      end
`endif
    end
  end

`ifdef MOD_SEQ_TIMEOUT_EN
  // Holding the count at zero outside WAIT is the same as clearing it on entry.
  always_ff @(posedge clk) begin
    if (rst || state_q != S_WAIT) wd_cnt_q <= '0;
    else                          wd_cnt_q <= wd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) abort_cnt_q <= 1'b0;
    else     abort_cnt_q <= (state_q == S_ABORT) && !abort_cnt_q;
  end

  assign mod_rst_o = (state_q == S_ABORT);
`else
  assign mod_rst_o = 1'b0;
`endif

endmodule

// File: tb/tb_modulo_job_sequencer.sv
// Directed self-checking bench for modulo_job_sequencer; the modulo unit is
// played by the stimulus process with a per-vector latency.
module tb_modulo_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] zahl1_i;
  logic [31:0] zahl2_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rest_o;
  logic        resp_err_o;
  logic        mod_start_o;
  logic [31:0] mod_zahl1_o;
  logic [31:0] mod_zahl2_o;
  logic        mod_valid_i;
  logic [31:0] mod_erg_i;
  logic        mod_rst_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  modulo_job_sequencer #(.WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .zahl1_i      (zahl1_i),
    .zahl2_i      (zahl2_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rest_o  (resp_rest_o),
    .resp_err_o   (resp_err_o),
    .mod_start_o  (mod_start_o),
    .mod_zahl1_o  (mod_zahl1_o),
    .mod_zahl2_o  (mod_zahl2_o),
    .mod_valid_i  (mod_valid_i),
    .mod_erg_i    (mod_erg_i),
    .mod_rst_o    (mod_rst_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z1;
    logic [31:0] z2;
    int unsigned lat;
    int unsigned hold;
    logic [31:0] exp_rest;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One complete job: request handshake, unit model, response with optional backpressure.
  task automatic run_job(input vec_t v);
    logic ok;
    @(negedge clk);
    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1;
    zahl1_i     = v.z1;
    zahl2_i     = v.z2;
    @(negedge clk);
    req_valid_i = 1'b0;
    zahl1_i     = '0;
    zahl2_i     = '0;
    chk("busy_after_req", busy_o, 1);
    chk("req_ready_busy", req_ready_o, 0);
    if (v.z2 != 0) begin
      chk("start_at_k1", mod_start_o, 1);
      mod_valid_i = 1'b1;
      mod_erg_i   = 32'hDEAD_BEEF;
      @(negedge clk);
      mod_valid_i = 1'b0;
      mod_erg_i   = '0;
      ok = 1'b1;
      for (int unsigned i = 0; i < v.lat - 1; i++) begin
        if (mod_start_o !== 1'b0 || resp_valid_o !== 1'b0 || busy_o !== 1'b1 ||
            mod_zahl1_o !== v.z1 || mod_zahl2_o !== v.z2) ok = 1'b0;
        @(negedge clk);
      end
      chk("wait_hold_operands", ok, 1);
      mod_valid_i = 1'b1;
      mod_erg_i   = v.z1 % v.z2;
      @(negedge clk);
      mod_valid_i = 1'b0;
      mod_erg_i   = '0;
    end else begin
      chk("zero_div_no_start", mod_start_o, 0);
    end
    chk("resp_valid", resp_valid_o, 1);
    chk("resp_rest", resp_rest_o, v.exp_rest);
    chk("resp_err", resp_err_o, v.exp_err);
    ok = 1'b1;
    for (int unsigned i = 0; i < v.hold; i++) begin
      mod_valid_i = 1'b1;
      mod_erg_i   = 32'hDEAD_BEEF;
      @(negedge clk);
      if (resp_valid_o !== 1'b1 || resp_rest_o !== v.exp_rest ||
          resp_err_o !== v.exp_err || req_ready_o !== 1'b0) ok = 1'b0;
    end
    mod_valid_i = 1'b0;
    mod_erg_i   = '0;
    if (v.hold > 0) chk("backpressure_hold", ok, 1);
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    chk("resp_consumed", resp_valid_o, 0);
    chk("req_ready_after_resp", req_ready_o, 1);
    chk("busy_idle", busy_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    vecs[0] = '{z1: 32'd17,         z2: 32'd5,  lat: 12, hold: 0,  exp_rest: 32'd2,   exp_err: 1'b0};
    vecs[1] = '{z1: 32'd4,          z2: 32'd9,  lat: 5,  hold: 0,  exp_rest: 32'd4,   exp_err: 1'b0};
    vecs[2] = '{z1: 32'd123,        z2: 32'd0,  lat: 0,  hold: 0,  exp_rest: 32'd123, exp_err: 1'b1};
    vecs[3] = '{z1: 32'd100,        z2: 32'd7,  lat: 4,  hold: 10, exp_rest: 32'd2,   exp_err: 1'b0};
    vecs[4] = '{z1: 32'd0,          z2: 32'd3,  lat: 2,  hold: 1,  exp_rest: 32'd0,   exp_err: 1'b0};
    vecs[5] = '{z1: 32'hFFFF_FFFF,  z2: 32'd16, lat: 3,  hold: 0,  exp_rest: 32'd15,  exp_err: 1'b0};

    rst          = 1'b1;
    req_valid_i  = 1'b0;
    zahl1_i      = '0;
    zahl2_i      = '0;
    resp_ready_i = 1'b0;
    mod_valid_i  = 1'b0;
    mod_erg_i    = '0;

    repeat (3) @(negedge clk);
    chk("reset_ctrl_outputs",
        {req_ready_o, resp_valid_o, resp_err_o, mod_start_o, mod_rst_o, busy_o}, 0);
    chk("reset_data_outputs", {resp_rest_o, mod_zahl1_o}, 0);
    chk("reset_zahl2", mod_zahl2_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready_o, 1);

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // Stray completion flag while idle.
    mod_valid_i = 1'b1;
    mod_erg_i   = 32'hDEAD_BEEF;
    @(negedge clk);
    mod_valid_i = 1'b0;
    mod_erg_i   = '0;
    chk("stray_idle_no_resp", {resp_valid_o, busy_o, req_ready_o}, 3'b001);

    // Reset asserted while waiting on 50 mod 3.
    req_valid_i = 1'b1;
    zahl1_i     = 32'd50;
    zahl2_i     = 32'd3;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_wait_before_reset", {busy_o, mod_start_o}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl_outputs",
        {req_ready_o, resp_valid_o, resp_err_o, mod_start_o, mod_rst_o, busy_o}, 0);
    chk("midrst_data_outputs", {resp_rest_o, mod_zahl1_o}, 0);
    chk("midrst_zahl2", mod_zahl2_o, 0);
    rst         = 1'b0;
    mod_valid_i = 1'b1;
    mod_erg_i   = 32'd2;
    @(negedge clk);
    mod_valid_i = 1'b0;
    mod_erg_i   = '0;
    @(negedge clk);
    chk("midrst_no_response", {resp_valid_o, busy_o, req_ready_o}, 3'b001);
    v = '{z1: 32'd100, z2: 32'd7, lat: 3, hold: 0, exp_rest: 32'd2, exp_err: 1'b0};
    run_job(v);

`ifdef MOD_SEQ_TIMEOUT_EN
    begin
      int first_rst = -1;
      int rst_cycles = 0;
      int resp_cycle = -1;
      @(negedge clk);
      req_valid_i = 1'b1;
      zahl1_i     = 32'd9;
      zahl2_i     = 32'd4;
      for (int c = 1; c <= 60 && resp_cycle < 0; c++) begin
        @(negedge clk);
        req_valid_i = 1'b0;
        if (mod_rst_o === 1'b1) begin
          rst_cycles++;
          if (first_rst < 0) first_rst = c;
        end
        if (resp_valid_o === 1'b1) resp_cycle = c;
      end
      chk("timeout_mod_rst_start", first_rst, 18);
      chk("timeout_mod_rst_len", rst_cycles, 2);
      chk("timeout_resp_cycle", resp_cycle, 20);
      chk("timeout_resp", {resp_err_o, resp_rest_o}, {1'b1, 32'd0});
      resp_ready_i = 1'b1;
      @(negedge clk);
      resp_ready_i = 1'b0;
      mod_valid_i  = 1'b1;
      mod_erg_i    = 32'hDEAD_BEEF;
      @(negedge clk);
      mod_valid_i = 1'b0;
      mod_erg_i   = '0;
      chk("timeout_stray_idle", {resp_valid_o, busy_o, req_ready_o, mod_rst_o}, 4'b0010);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
